// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcodes, control encodings and control bundle layout.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MDU     = 7'b0000001;

    localparam logic [1:0] RS_UPPER = 2'b00;
    localparam logic [1:0] RS_LINK  = 2'b01;
    localparam logic [1:0] RS_ALU   = 2'b10;

    localparam logic [1:0] SB_REG  = 2'b00;
    localparam logic [1:0] SB_UIMM = 2'b01;
    localparam logic [1:0] SB_JAL  = 2'b10;
    localparam logic [1:0] SB_IMM  = 2'b11;

    // ex_ctrl = {op, funct3, funct7, alu_src_a, alu_src_b, alu_result}
    localparam int EX_W        = 21;
    // mem_ctrl = {mem_write, jump, branch, ls_type}; flags sit above ls_type
    localparam int MEM_FLAGS_W = 3;
    // wb_ctrl = {reg_write, mem_to_reg, reg_src}
    localparam int WB_W        = 4;
    localparam int WB_RW_BIT   = 3;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Decode-stage handshake: decoded instruction fields offered to the control pipeline.
interface decode_ctrl_pipe_if;
    logic       id_valid;
    logic       id_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;

    modport master (output id_valid, op, funct3, funct7, input id_ready);
    modport slave  (input id_valid, op, funct3, funct7, output id_ready);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational control decoder: instruction fields -> EX/MEM/WB control bundles.
// RV_MDU_EN makes OP with funct7=0000001 (mul/div) legal.
module ctrl_decode
    import decode_pkg::*;
#(
    parameter int LSW = 3
) (
    input  logic [6:0]                 i_op,
    input  logic [2:0]                 i_funct3,
    input  logic [6:0]                 i_funct7,
    output logic [EX_W-1:0]            o_ex_ctrl,
    output logic [LSW+MEM_FLAGS_W-1:0] o_mem_ctrl,
    output logic [WB_W-1:0]            o_wb_ctrl,
    output logic                       o_illegal
);

    logic       w_reg_write, w_mem_to_reg, w_alu_src_a, w_alu_result;
    logic       w_mem_write, w_jump, w_branch, w_illegal;
    logic [1:0] w_reg_src, w_alu_src_b;

    always_comb begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b0;
        w_reg_src    = RS_ALU;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SB_REG;
        w_alu_result = 1'b1;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (i_op)
            OPC_LUI:    begin w_reg_src = RS_UPPER; w_alu_src_b = SB_UIMM; w_alu_result = 1'b0; end
            OPC_AUIPC:  begin w_reg_src = RS_UPPER; w_alu_src_b = SB_UIMM; w_alu_src_a = 1'b0; end
            OPC_JAL:    begin w_reg_src = RS_LINK; w_alu_src_b = SB_JAL; w_alu_src_a = 1'b0; w_jump = 1'b1; end
            OPC_JALR:   begin w_reg_src = RS_LINK; w_alu_src_b = SB_IMM; w_jump = 1'b1; end
            OPC_BRANCH: begin w_branch = 1'b1; w_reg_write = 1'b0; end
            OPC_LOAD:   begin w_alu_src_b = SB_IMM; w_mem_to_reg = 1'b1; end
            OPC_STORE:  begin w_alu_src_b = SB_IMM; w_mem_write = 1'b1; w_reg_write = 1'b0; end
            OPC_OPIMM:  begin w_alu_src_b = SB_IMM; end
            OPC_OP: begin
`ifndef RV_MDU_EN
                if (i_funct7 == F7_MDU) w_illegal = 1'b1;
`endif
            end
            default:    w_illegal = 1'b1;
        endcase
        // An unsupported instruction must never commit architectural state
        if (w_illegal) begin
            w_reg_write = 1'b0;
            w_mem_write = 1'b0;
        end
    end

    assign o_ex_ctrl  = {i_op, i_funct3, i_funct7, w_alu_src_a, w_alu_src_b, w_alu_result};
    assign o_mem_ctrl = {w_mem_write, w_jump, w_branch, LSW'(i_funct3)};
    assign o_wb_ctrl  = {w_reg_write, w_mem_to_reg, w_reg_src};
    assign o_illegal  = w_illegal;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// EX/MEM/WB control pipeline fed by the decoder, with stall/flush and a multicycle MDU hold.
// RV_MDU_EN enables mul/div decode and the EX occupancy counter; otherwise mdu_busy is 0.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int LSW     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    decode_ctrl_pipe_if.slave          id,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       ex_valid,
    output logic                       mem_valid,
    output logic                       wb_valid,
    output logic [EX_W-1:0]            ex_ctrl,
    output logic [LSW+MEM_FLAGS_W-1:0] mem_ctrl,
    output logic [WB_W-1:0]            wb_ctrl,
    output logic                       illegal,
    output logic                       mdu_busy
);

    localparam int MEM_W = LSW + MEM_FLAGS_W;

    if (MUL_LAT < 1 || MUL_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 31 || LSW < 1) begin : g_bad_cfg
        $error("decode_ctrl_pipe: MUL_LAT/DIV_LAT/LSW out of range");
    end

    logic [EX_W-1:0]  w_dec_ex;
    logic [MEM_W-1:0] w_dec_mem;
    logic [WB_W-1:0]  w_dec_wb;
    logic             w_dec_illegal;
    logic             w_mdu_busy, w_ex_adv, w_accept, w_ex_to_mem;

    logic             r_ex_valid, r_ex_illegal, r_mem_valid, r_wb_valid;
    logic [EX_W-1:0]  r_ex_ctrl;
    logic [MEM_W-1:0] r_ex_mem, r_mem_ctrl;
    logic [WB_W-1:0]  r_ex_wb, r_mem_wb, r_wb_ctrl;

    ctrl_decode #(.LSW(LSW)) u_dec (
        .i_op       (id.op),
        .i_funct3   (id.funct3),
        .i_funct7   (id.funct7),
        .o_ex_ctrl  (w_dec_ex),
        .o_mem_ctrl (w_dec_mem),
        .o_wb_ctrl  (w_dec_wb),
        .o_illegal  (w_dec_illegal)
    );

    assign w_ex_adv    = !stall && !w_mdu_busy;
    assign id.id_ready = w_ex_adv && !flush;
    assign w_accept    = id.id_valid && id.id_ready;
    // The EX instruction is killed by flush, so it never moves on to MEM that edge
    assign w_ex_to_mem = w_ex_adv && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_illegal <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_mem     <= '0;
            r_ex_wb      <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_ctrl   <= '0;
            r_mem_wb     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_ctrl    <= '0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_ex_adv) begin
                r_ex_valid <= w_accept;
                if (w_accept) begin
                    r_ex_ctrl    <= w_dec_ex;
                    r_ex_mem     <= w_dec_mem;
                    r_ex_wb      <= w_dec_wb;
                    r_ex_illegal <= w_dec_illegal;
                end
            end
            r_mem_valid <= r_ex_valid && w_ex_to_mem;
            if (w_ex_to_mem) begin
                r_mem_ctrl <= r_ex_mem;
                r_mem_wb   <= r_ex_wb;
            end
            r_wb_valid <= r_mem_valid;
            r_wb_ctrl  <= r_mem_wb;
        end
    end

`ifdef RV_MDU_EN
    logic [4:0] r_mdu_cnt;
    logic       w_mdu_start;

    assign w_mdu_start = w_accept && (id.op == OPC_OP) && (id.funct7 == F7_MDU);

    // Counts remaining extra EX cycles; keeps running even while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (flush) begin
            r_mdu_cnt <= '0;
        end else if (w_mdu_start) begin
            r_mdu_cnt <= id.funct3[2] ? 5'(DIV_LAT - 1) : 5'(MUL_LAT - 1);
        end else if (r_mdu_cnt != 5'd0) begin
            r_mdu_cnt <= r_mdu_cnt - 5'd1;
        end
    end

    assign w_mdu_busy = (r_mdu_cnt != 5'd0);
`else
    assign w_mdu_busy = 1'b0;
`endif

    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;
    assign ex_ctrl   = r_ex_ctrl;
    // Side-effecting flags read 0 in an empty stage; data fields keep their held values
    assign mem_ctrl  = {r_mem_ctrl[MEM_W-1:LSW] & {MEM_FLAGS_W{r_mem_valid}}, r_mem_ctrl[LSW-1:0]};
    assign wb_ctrl   = {r_wb_ctrl[WB_RW_BIT] & r_wb_valid, r_wb_ctrl[WB_RW_BIT-1:0]};
    assign illegal   = r_ex_illegal && r_ex_valid;
    assign mdu_busy  = w_mdu_busy;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe (default parameters; honours RV_MDU_EN).
module tb_decode_ctrl_pipe;

    localparam int LSW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid, mem_valid, wb_valid, illegal, mdu_busy;
    logic [20:0] ex_ctrl;
    logic [5:0]  mem_ctrl;
    logic [3:0]  wb_ctrl;
    int          total = 0;
    int          bad = 0;

    decode_ctrl_pipe_if id_if ();

    decode_ctrl_pipe #(.MUL_LAT(3), .DIV_LAT(16), .LSW(LSW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id        (id_if),
        .stall     (stall),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .mem_valid (mem_valid),
        .wb_valid  (wb_valid),
        .ex_ctrl   (ex_ctrl),
        .mem_ctrl  (mem_ctrl),
        .wb_ctrl   (wb_ctrl),
        .illegal   (illegal),
        .mdu_busy  (mdu_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        id_if.id_valid = v;
        id_if.op       = o;
        id_if.funct3   = f3;
        id_if.funct7   = f7;
        if (v) $display("txn: op=%b funct3=%b funct7=%b stall=%0b flush=%0b", o, f3, f7, stall, flush);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
        chk("rst_ex_ctrl", ex_ctrl, 32'd0);
        chk("rst_mem_ctrl", mem_ctrl, 32'd0);
        chk("rst_wb_ctrl", wb_ctrl, 32'd0);
        chk("rst_illegal", illegal, 32'd0);
        chk("rst_mdu_busy", mdu_busy, 32'd0);
        chk("rst_id_ready", id_if.id_ready, 32'd1);
        rst_n = 1'b1;

        // ADD: EX at +1, MEM at +2, WB at +3
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        #1 chk("add_ready", id_if.id_ready, 32'd1);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("add_ex_valid", ex_valid, 32'd1);
        chk("add_ex_ctrl", ex_ctrl, {7'b0110011, 3'b000, 7'b0000000, 1'b1, 2'b00, 1'b1});
        chk("add_mem_early", mem_valid, 32'd0);
        tick();
        chk("add_mem_valid", {30'd0, ex_valid, mem_valid}, 32'b01);
        chk("add_mem_ctrl", mem_ctrl, 32'd0);
        tick();
        chk("add_wb_valid", {30'd0, mem_valid, wb_valid}, 32'b01);
        chk("add_wb_ctrl", wb_ctrl, 32'b1010);
        tick();
        chk("add_wb_gone", wb_valid, 32'd0);
        chk("add_wb_gated", wb_ctrl, 32'b0010);

        // SW: store flags in MEM, no register write
        drive(1'b1, 7'b0100011, 3'b010, 7'b0000000);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("sw_ex_ctrl", ex_ctrl, {7'b0100011, 3'b010, 7'b0000000, 1'b1, 2'b11, 1'b1});
        tick();
        chk("sw_mem_ctrl", mem_ctrl, 32'b100010);
        tick();
        chk("sw_wb_valid", wb_valid, 32'd1);
        chk("sw_wb_ctrl", wb_ctrl, 32'b0010);
        chk("sw_mem_gated", mem_ctrl, 32'b000010);

        // LUI: alu_result=0, reg_src=00
        drive(1'b1, 7'b0110111, 3'b000, 7'b0000000);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("lui_ex_ctrl", ex_ctrl, {7'b0110111, 3'b000, 7'b0000000, 1'b1, 2'b01, 1'b0});
        tick(); tick();
        chk("lui_wb_ctrl", {27'd0, wb_valid, wb_ctrl}, 32'b11000);

        // ADD stalled two cycles in EX
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick();
        stall = 1'b1;
        drive(1'b1, 7'b0010011, 3'b110, 7'b0000000);
        #1 chk("stall_ready", id_if.id_ready, 32'd0);
        tick();
        chk("stall1_ex", {30'd0, ex_valid, mem_valid}, 32'b10);
        chk("stall1_ex_ctrl", ex_ctrl, {7'b0110011, 3'b000, 7'b0000000, 1'b1, 2'b00, 1'b1});
        tick();
        chk("stall2_ex", {30'd0, ex_valid, mem_valid}, 32'b10);
        chk("stall2_ex_ctrl", ex_ctrl, {7'b0110011, 3'b000, 7'b0000000, 1'b1, 2'b00, 1'b1});
        stall = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        chk("stall_mem", {30'd0, ex_valid, mem_valid}, 32'b01);
        tick();
        chk("stall_wb", {27'd0, wb_valid, wb_ctrl}, 32'b11010);

        // JAL in EX killed by flush+stall in the same cycle
        drive(1'b1, 7'b1101111, 3'b000, 7'b0000000);
        tick();
        chk("jal_ex_ctrl", {ex_valid, ex_ctrl}, {1'b1, 7'b1101111, 3'b000, 7'b0000000, 1'b0, 2'b10, 1'b1});
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        #1 chk("flush_ready", id_if.id_ready, 32'd0);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("flush_ex", {30'd0, ex_valid, mem_valid}, 32'b00);
        tick();
        chk("flush_mem", {29'd0, ex_valid, mem_valid, mem_ctrl[4]}, 32'b000);
        tick();
        chk("flush_wb", {27'd0, wb_valid, wb_ctrl[3]}, 32'd0);

        // Unsupported opcode
        drive(1'b1, 7'b1111111, 3'b000, 7'b0000000);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("ill_flag", {30'd0, ex_valid, illegal}, 32'b11);
        tick();
        chk("ill_cleared", illegal, 32'd0);
        tick();
        chk("ill_wb", {27'd0, wb_valid, wb_ctrl}, 32'b10010);

        // DIV: multicycle with the MDU, illegal without it
        drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
`ifdef RV_MDU_EN
        chk("div_legal", {30'd0, ex_valid, illegal}, 32'b10);
        n = 0;
        while (mdu_busy === 1'b1 && n < 40) begin
            chk("div_ready", {30'd0, id_if.id_ready, mem_valid}, 32'b00);
            n++;
            tick();
        end
        chk("div_busy_cycles", n, 32'd15);
        chk("div_held", {30'd0, ex_valid, mem_valid}, 32'b10);
        tick();
        chk("div_to_mem", {30'd0, ex_valid, mem_valid}, 32'b01);
`else
        chk("div_illegal", {30'd0, illegal, mdu_busy}, 32'b10);
        chk("div_ready", id_if.id_ready, 32'd1);
`endif
        tick(); tick(); tick();

        // Asynchronous reset in the middle of a DIV / full pipe
        drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
        tick();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
        chk("async_rst_busy", {30'd0, mdu_busy, illegal}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick(); drive(1'b0, 7'd0, 3'd0, 7'd0);
        chk("post_rst_pipe", {29'd0, ex_valid, mem_valid, wb_valid}, 32'b100);
        chk("post_rst_busy", mdu_busy, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL provide parameter MUL_LAT, default 3, meaning multiply occupancy in EX, in cycles (1..15).
REQ-002 SHALL provide parameter DIV_LAT, default 16, meaning divide occupancy in EX, in cycles (1..31).
REQ-003 SHALL provide parameter LSW, default 3, meaning load/store type width (funct3 copy).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 id_valid  input  1  decoded fields valid this cycle.
REQ-007 id_ready  output  1  stage accepts fields this cycle.
REQ-008 op / funct3 / funct7  input  7 / 3 / 7  instruction fields.
REQ-009 stall  input  1  downstream hazard stall.
REQ-010 flush  input  1  kill younger instructions (taken branch/jump).
REQ-011 ex_valid, mem_valid, wb_valid  output  1 each  stage occupancy.
REQ-012 ex_ctrl  output  21  {op, funct3, funct7, alu_src_a, alu_src_b[1:0], alu_result}.
REQ-013 mem_ctrl  output  3+LSW  {mem_write, jump, branch, ls_type}.
REQ-014 wb_ctrl  output  4  {reg_write, mem_to_reg, reg_src[1:0]}.
REQ-015 illegal  output  1  registered with EX: unsupported opcode in EX.
REQ-016 mdu_busy  output  1  multicycle op occupying EX.

Function
REQ-017 Decode SHALL classify LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP by full 7-bit opcode compare; any other opcode sets illegal and forces reg_write=0, mem_write=0.
REQ-018 Encodings: reg_src 00 LUI/AUIPC, 01 JAL/JALR, 10 else; alu_src_b 01 U-type, 10 JAL, 11 OP-IMM/LOAD/JALR/STORE, 00 else; alu_src_a=0 for JAL/AUIPC; alu_result=0 only for LUI; reg_write=0 for BRANCH/STORE/illegal.
REQ-019 Accept = id_valid & id_ready; id_ready = !stall & !mdu_busy & !flush.
REQ-020 Accept SHALL load EX register next edge; latency fields->ex_ctrl = 1 cycle, ->mem_ctrl = 2, ->wb_ctrl = 3.
REQ-021 No accept while EX advancing SHALL load EX with valid=0 (bubble).
REQ-022 stall: EX holds contents; MEM receives bubble; WB advances from MEM.
REQ-023 flush: ex_valid cleared next edge; MEM/WB unaffected; flush with stall in same cycle -> flush wins.
REQ-024 Invalid stages SHALL drive control outputs as held values but consumers gate on *_valid; reg_write/mem_write/branch/jump SHALL read 0 when stage invalid.
REQ-025 No stage SHALL be lost or duplicated; each accepted instruction appears in WB exactly once unless flushed in EX.

Reset
REQ-026 rst_n low: all valids 0, all ctrl registers 0, illegal 0, mdu counter 0, mdu_busy 0; id_ready follows REQ-019 combinationally.
REQ-027 Reset asserted mid multicycle op SHALL abandon it; first post-reset edge behaves as empty pipe.

Configuration
REQ-028 Macro RV_MDU_EN defined: OP with funct7=0000001 legal; on entering EX, 5-bit counter loads MUL_LAT-1 (funct3[2]=0) or DIV_LAT-1 (funct3[2]=1); mdu_busy=(counter!=0); while busy EX holds, MEM gets bubbles; counter decrements per cycle, independent of stall; flush clears counter.
REQ-029 RV_MDU_EN undefined: funct7=0000001 on OP flagged illegal; counter absent; mdu_busy tied 0.

Structure
REQ-030 Shared package decode_pkg SHALL hold opcode localparams, reg_src/alu_src_b encodings and ctrl field widths/offsets.
REQ-031 Combinational decoder SHALL be sub-module ctrl_decode (fields -> ex/mem/wb bundles + illegal); pipeline registers and MDU counter stay in top.

Verification
REQ-032 ADD (op=0110011, funct7=0) accepted at cycle 0 -> ex_valid cycle 1, wb_valid cycle 3 with wb_ctrl=4'b1010.
REQ-033 SW (0100011) -> mem_ctrl mem_write=1, ls_type=010; wb reg_write=0; LUI -> alu_result=0, reg_src=00.
REQ-034 stall held 2 cycles with ADD in EX -> EX held, two MEM bubbles, id_ready=0, then ADD reaches WB at cycle 5.
REQ-035 flush and stall same cycle with JAL in EX -> ex_valid=0 next cycle, no WB for it.
REQ-036 RV_MDU_EN, DIV (funct3=100), DIV_LAT=16 -> mdu_busy 15 cycles, id_ready=0 throughout; without macro -> illegal=1.
REQ-037 opcode 1111111 -> illegal=1, reg_write=0; rst_n low mid-DIV -> all valids 0 asynchronously.
